// File: rtl/vector_permute_seq_ctrl.sv
// Vector permute sequencing control: decodes Fxv permute opcodes into registered
// datapath controls and splits large element shifts into STEP_MAX-bounded passes.
package vector_permute_pkg;
  typedef logic [9:0] fxv_opcd_t;
  typedef logic [1:0] permute_size_t;

  localparam fxv_opcd_t XO_FXVPCKBU  = 10'd1;
  localparam fxv_opcd_t XO_FXVPCKBL  = 10'd2;
  localparam fxv_opcd_t XO_FXVUPCKBL = 10'd3;
  localparam fxv_opcd_t XO_FXVUPCKBR = 10'd4;
  localparam fxv_opcd_t XO_FXVSPLATH = 10'd5;
  localparam fxv_opcd_t XO_FXVSPLATB = 10'd6;
  localparam fxv_opcd_t XO_FXVSHH    = 10'd7;
  localparam fxv_opcd_t XO_FXVSHB    = 10'd8;
  localparam fxv_opcd_t XO_FXVSEL    = 10'd9;

  typedef enum logic [2:0] {
    PERMUTE_PACK   = 3'd0,
    PERMUTE_SPLAT  = 3'd1,
    PERMUTE_SPLATB = 3'd2,
    PERMUTE_SHIFT  = 3'd3,
    PERMUTE_SHIFTB = 3'd4,
    PERMUTE_SELECT = 3'd5
  } permute_op_t;

  typedef struct packed {
    permute_op_t   op;
    logic          pack_upper;
    logic          pack_lower;
    logic          unpack_left;
    logic          unpack_right;
    logic [31:0]   g;
    permute_size_t size;
  } ctrl_t;
endpackage

module vector_permute_seq_ctrl import vector_permute_pkg::*; #(
  parameter int NUM_ELEMS = 8,
  parameter int ELEM_SIZE = 16,
  parameter int SHIFT_W   = 5,
  parameter int STEP_MAX  = 4,
  parameter int LATENCY   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid,
  input  fxv_opcd_t          xo,
  input  logic [31:0]        g,
  input  permute_size_t      size,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               stall,
  output logic               ready,
  output logic               busy,
  output logic               issue,
  output permute_op_t        op,
  output logic               pack_upper,
  output logic               pack_lower,
  output logic               unpack_left,
  output logic               unpack_right,
  output logic [31:0]        g_out,
  output permute_size_t      size_out,
  output logic [SHIFT_W-1:0] shift_out,
  output logic               pass_first,
  output logic               pass_last,
  output logic               keep_res,
  output logic               result_avail
);
  typedef enum logic {IDLE, PASS} state_t;

  localparam logic [SHIFT_W-1:0] STEP = SHIFT_W'(STEP_MAX);

  state_t             state_q, state_d;
  ctrl_t              ctrl_q, ctrl_d, dec;
  logic [SHIFT_W-1:0] rem_q, rem_d, shamt_q, shamt_d;
  logic               neg_q, neg_d, issue_q, issue_d, first_q, first_d, last_q, last_d;
  logic [LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic               accept, is_shift, src_neg;
  logic [SHIFT_W-1:0] mag_in, src_mag, step, pass_amt;

  assign ready = ~reset & ((state_q == IDLE) | last_q);
  assign busy  = (state_q == PASS) & ~last_q;

  always_comb begin
    accept   = valid & ready & ~stall;
    // magnitude taken unsigned so the most negative shift still has a valid |shift|
    mag_in   = shift[SHIFT_W-1] ? (~shift + SHIFT_W'(1)) : shift;
    dec      = '0;
    dec.g    = g;
    dec.size = size;
    is_shift = 1'b0;
    case (xo)
      XO_FXVPCKBU:  dec.pack_upper   = 1'b1;
      XO_FXVPCKBL:  dec.pack_lower   = 1'b1;
      XO_FXVUPCKBL: dec.unpack_left  = 1'b1;
      XO_FXVUPCKBR: dec.unpack_right = 1'b1;
      XO_FXVSPLATH: dec.op = PERMUTE_SPLAT;
      XO_FXVSPLATB: dec.op = PERMUTE_SPLATB;
      XO_FXVSHH:    begin dec.op = PERMUTE_SHIFT;  is_shift = 1'b1; end
      XO_FXVSHB:    begin dec.op = PERMUTE_SHIFTB; is_shift = 1'b1; end
      XO_FXVSEL:    dec.op = PERMUTE_SELECT;
      default:      dec.op = PERMUTE_PACK;
    endcase

    src_mag  = accept ? (is_shift ? mag_in : '0) : rem_q;
    src_neg  = accept ? (is_shift & shift[SHIFT_W-1]) : neg_q;
    step     = (src_mag > STEP) ? STEP : src_mag;
    pass_amt = src_neg ? (~step + SHIFT_W'(1)) : step;

    state_d    = state_q;
    ctrl_d     = ctrl_q;
    rem_d      = rem_q;
    shamt_d    = shamt_q;
    neg_d      = neg_q;
    issue_d    = issue_q;
    first_d    = first_q;
    last_d     = last_q;
    vld_pipe_d = vld_pipe_q;
    if (!stall) begin
      issue_d       = 1'b0;
      first_d       = 1'b0;
      last_d        = 1'b0;
      vld_pipe_d[0] = last_q;
      for (int i = 1; i < LATENCY; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
      if (accept) begin
        state_d = PASS;
        ctrl_d  = dec;
        neg_d   = src_neg;
        rem_d   = src_mag - step;
        shamt_d = pass_amt;
        issue_d = 1'b1;
        first_d = 1'b1;
        last_d  = (src_mag == step);
      end else if (state_q == PASS && !last_q) begin
        rem_d   = src_mag - step;
        shamt_d = pass_amt;
        issue_d = 1'b1;
        last_d  = (src_mag == step);
      end else if (state_q == PASS) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      rem_q      <= '0;
      shamt_q    <= '0;
      neg_q      <= 1'b0;
      issue_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      rem_q      <= rem_d;
      shamt_q    <= shamt_d;
      neg_q      <= neg_d;
      issue_q    <= issue_d;
      first_q    <= first_d;
      last_q     <= last_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign issue        = issue_q;
  assign op           = ctrl_q.op;
  assign pack_upper   = ctrl_q.pack_upper;
  assign pack_lower   = ctrl_q.pack_lower;
  assign unpack_left  = ctrl_q.unpack_left;
  assign unpack_right = ctrl_q.unpack_right;
  assign g_out        = ctrl_q.g;
  assign size_out     = ctrl_q.size;
  assign shift_out    = shamt_q;
  assign pass_first   = first_q;
  assign pass_last    = last_q;
  assign keep_res     = ~stall & ~reset;
  assign result_avail = vld_pipe_q[LATENCY-1];

`ifndef SYNTHESIS
  if (NUM_ELEMS < 1 || ELEM_SIZE < 1 || LATENCY < 1 || STEP_MAX < 1 ||
      STEP_MAX > 2**(SHIFT_W-1)) begin : g_param_err
    $error("vector_permute_seq_ctrl: illegal parameter set");
  end

  a_valid_ready: assert property (@(posedge clk) disable iff (reset) valid |-> ready);
  a_valid_stall: assert property (@(posedge clk) disable iff (reset)
                                  (stall && $past(stall)) |-> $stable(valid));
`endif
endmodule

// File: tb/tb_vector_permute_seq_ctrl.sv
// Directed bench for vector_permute_seq_ctrl with hand-computed expectations
// (SHIFT_W=5, STEP_MAX=4, LATENCY=1).
module tb_vector_permute_seq_ctrl;
  import vector_permute_pkg::*;

  logic          clk, reset, valid, stall;
  fxv_opcd_t     xo;
  logic [31:0]   g;
  permute_size_t size;
  logic [4:0]    shift;
  logic          ready, busy, issue, pack_upper, pack_lower, unpack_left, unpack_right;
  permute_op_t   op;
  logic [31:0]   g_out;
  permute_size_t size_out;
  logic [4:0]    shift_out;
  logic          pass_first, pass_last, keep_res, result_avail;

  int checks = 0;
  int errors = 0;

  vector_permute_seq_ctrl #(.NUM_ELEMS(8), .ELEM_SIZE(16), .SHIFT_W(5), .STEP_MAX(4), .LATENCY(1)) dut (
    .clk(clk), .reset(reset), .valid(valid), .xo(xo), .g(g), .size(size), .shift(shift),
    .stall(stall), .ready(ready), .busy(busy), .issue(issue), .op(op),
    .pack_upper(pack_upper), .pack_lower(pack_lower), .unpack_left(unpack_left),
    .unpack_right(unpack_right), .g_out(g_out), .size_out(size_out), .shift_out(shift_out),
    .pass_first(pass_first), .pass_last(pass_last), .keep_res(keep_res),
    .result_avail(result_avail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input fxv_opcd_t x, input logic [4:0] sh, input logic [31:0] gw);
    valid = 1'b1; xo = x; shift = sh; g = gw; size = 2'd1;
    tick();
    valid = 1'b0;
  endtask

  // pass checks: issue, first, last, shift amount
  task automatic chk_pass(input string tag, input logic f, input logic l, input logic [4:0] sh);
    chk({tag, ".issue"}, issue, 1);
    chk({tag, ".first"}, pass_first, f);
    chk({tag, ".last"}, pass_last, l);
    chk({tag, ".shift"}, shift_out, sh);
  endtask

  fxv_opcd_t   dec_xo [10] = '{XO_FXVPCKBU, XO_FXVPCKBL, XO_FXVUPCKBL, XO_FXVUPCKBR,
                               XO_FXVSPLATH, XO_FXVSPLATB, XO_FXVSHH, XO_FXVSHB,
                               XO_FXVSEL, 10'h3FF};
  permute_op_t dec_op [10] = '{PERMUTE_PACK, PERMUTE_PACK, PERMUTE_PACK, PERMUTE_PACK,
                               PERMUTE_SPLAT, PERMUTE_SPLATB, PERMUTE_SHIFT, PERMUTE_SHIFTB,
                               PERMUTE_SELECT, PERMUTE_PACK};
  logic [3:0]  dec_fl [10] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000,
                               4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

  initial begin
    reset = 1'b1; valid = 1'b0; stall = 1'b0; xo = '0; g = '0; size = '0; shift = '0;
    #1;
    chk("rst.ready", ready, 0);
    chk("rst.issue", issue, 0);
    chk("rst.op", op, PERMUTE_PACK);
    chk("rst.keep", keep_res, 0);
    chk("rst.ra", result_avail, 0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("idle.ready", ready, 1);
    chk("idle.keep", keep_res, 1);
    tick();

    // 1: single-pass pack
    send(XO_FXVPCKBU, 5'd0, 32'hCAFE_0001);
    chk_pass("t1", 1, 1, 5'd0);
    chk("t1.pu", pack_upper, 1);
    chk("t1.op", op, PERMUTE_PACK);
    chk("t1.g", g_out, 32'hCAFE_0001);
    chk("t1.size", size_out, 2'd1);
    chk("t1.ra0", result_avail, 0);
    chk("t1.ready", ready, 1);
    tick();
    chk("t1.ra1", result_avail, 1);
    chk("t1.idle_issue", issue, 0);
    chk("t1.hold_g", g_out, 32'hCAFE_0001);
    tick();
    chk("t1.ra2", result_avail, 0);

    // decode table
    for (int i = 0; i < 10; i++) begin
      send(dec_xo[i], 5'd0, 32'(i));
      chk($sformatf("dec%0d.op", i), op, dec_op[i]);
      chk($sformatf("dec%0d.fl", i), {pack_upper, pack_lower, unpack_left, unpack_right}, dec_fl[i]);
      tick(); tick();
    end

    // 2: +11 -> 4,4,3
    send(XO_FXVSHH, 5'd11, 32'h2);
    chk_pass("t2p0", 1, 0, 5'd4);
    chk("t2p0.ready", ready, 0);
    chk("t2p0.busy", busy, 1);
    chk("t2p0.op", op, PERMUTE_SHIFT);
    tick();
    chk_pass("t2p1", 0, 0, 5'd4);
    chk("t2p1.ready", ready, 0);
    tick();
    chk_pass("t2p2", 0, 1, 5'd3);
    chk("t2p2.ready", ready, 1);
    chk("t2p2.busy", busy, 0);
    chk("t2p2.ra", result_avail, 0);
    tick();
    chk("t2.ra", result_avail, 1);
    tick();
    chk("t2.ra_off", result_avail, 0);

    // 3: -16 -> four passes of -4 (5'd28); then shift 0
    send(XO_FXVSHB, 5'b10000, 32'h3);
    chk_pass("t3p0", 1, 0, 5'd28);
    chk("t3.op", op, PERMUTE_SHIFTB);
    tick(); chk_pass("t3p1", 0, 0, 5'd28);
    tick(); chk_pass("t3p2", 0, 0, 5'd28);
    tick(); chk_pass("t3p3", 0, 1, 5'd28);
    tick(); chk("t3.ra", result_avail, 1);
    tick();
    send(XO_FXVSHB, 5'd0, 32'h4);
    chk_pass("t3z", 1, 1, 5'd0);
    tick(); chk("t3z.ra", result_avail, 1);
    tick();

    // 4: stall 3 cycles on pass 2 of 3
    send(XO_FXVSHH, 5'd11, 32'h5);
    tick();
    chk_pass("t4p1", 0, 0, 5'd4);
    stall = 1'b1;
    #1;
    chk("t4.keep", keep_res, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_pass($sformatf("t4s%0d", i), 0, 0, 5'd4);
      chk($sformatf("t4s%0d.ra", i), result_avail, 0);
    end
    stall = 1'b0;
    #1;
    chk("t4.keep1", keep_res, 1);
    tick();
    chk_pass("t4p2", 0, 1, 5'd3);
    tick();
    chk("t4.ra", result_avail, 1);
    tick();

    // 5: back-to-back +5 then -6
    send(XO_FXVSHH, 5'd5, 32'h6);
    chk_pass("t5a0", 1, 0, 5'd4);
    tick();
    chk_pass("t5a1", 0, 1, 5'd1);
    send(XO_FXVSHH, 5'b11010, 32'h7);
    chk_pass("t5b0", 1, 0, 5'd28);
    chk("t5b0.g", g_out, 32'h7);
    chk("t5.raA", result_avail, 1);
    tick();
    chk_pass("t5b1", 0, 1, 5'd30);
    chk("t5.gap", result_avail, 0);
    tick();
    chk("t5.raB", result_avail, 1);
    tick();

    // 6: reset during pass 2
    send(XO_FXVSHH, 5'd11, 32'h8);
    tick();
    chk_pass("t6p1", 0, 0, 5'd4);
    reset = 1'b1;
    #1;
    chk("t6.issue", issue, 0);
    chk("t6.shift", shift_out, 0);
    chk("t6.g", g_out, 0);
    chk("t6.busy", busy, 0);
    chk("t6.ready", ready, 0);
    chk("t6.ra", result_avail, 0);
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t6post%0d.ra", i), result_avail, 0);
      chk($sformatf("t6post%0d.issue", i), issue, 0);
    end
    chk("t6.ready_after", ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
